// File: rtl/fir_pkg.sv
// fir_pkg: shared FSM state type and width helpers for the FIR MAC sequencer
package fir_pkg;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) ;
    return r;
  endfunction
  function automatic int acc_size(input int d, input int c, input int n);
    return d + c + clog2(n);
  endfunction
endpackage

// File: rtl/fir_delay_line.sv
// fir_delay_line: N_TAPS-deep circular sample buffer with wrapping write pointer
// ports: wr_en/wr_data store at wr_ptr and advance it; rd_idx selects rd_data combinationally
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int DATA_SIZE = 9,
  parameter int N_TAPS = 3,
  localparam int AW = clog2(N_TAPS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic signed [DATA_SIZE-1:0] wr_data,
  input  logic [AW-1:0]               rd_idx,
  output logic signed [DATA_SIZE-1:0] rd_data,
  output logic [AW-1:0]               wr_ptr
);
  logic signed [DATA_SIZE-1:0] mem_q [N_TAPS];
  logic signed [DATA_SIZE-1:0] mem_d [N_TAPS];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  assign wr_ptr = wr_ptr_q;
  assign rd_data = mem_q[rd_idx];
  always_comb begin
    mem_d = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d = wr_ptr_q == AW'(N_TAPS - 1) ? '0 : wr_ptr_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_ptr_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
    end
endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed FIR, one shared multiplier stepped over all taps per sample
// ports: in_* sample handshake, coef_* run-time coefficient write (IDLE only), out_* result handshake, busy in MAC/OUT
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int DATA_SIZE = 9,
  parameter int COEF_SIZE = 9,
  parameter int N_TAPS = 3,
  parameter int ACC_SIZE = acc_size(DATA_SIZE, COEF_SIZE, N_TAPS),
  localparam int AW = clog2(N_TAPS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [DATA_SIZE-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        coef_wr,
  input  logic [AW-1:0]               coef_addr,
  input  logic signed [COEF_SIZE-1:0] coef_data,
  output logic signed [ACC_SIZE-1:0]  out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy
);
  state_e state_q, state_d;
  logic [AW-1:0] k_q, k_d, newest_q, newest_d, wr_ptr, rd_idx;
  logic signed [ACC_SIZE-1:0] acc_q, acc_d, out_data_q, out_data_d, sum;
  logic out_valid_q, out_valid_d;
  logic signed [COEF_SIZE-1:0] coef_q [N_TAPS];
  logic signed [COEF_SIZE-1:0] coef_d [N_TAPS];
  logic signed [DATA_SIZE-1:0] rd_data;
  logic signed [DATA_SIZE+COEF_SIZE-1:0] prod;
  assign in_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign out_data = out_data_q;
  assign out_valid = out_valid_q;
  // tap k reads x[n-k]; wrap below zero back to the top of the ring
  assign rd_idx = newest_q >= k_q ? newest_q - k_q : newest_q + AW'(N_TAPS) - k_q;
  assign prod = rd_data * coef_q[k_q];
  assign sum = (k_q == '0 ? '0 : acc_q) + ACC_SIZE'(prod);
  fir_delay_line #(.DATA_SIZE(DATA_SIZE), .N_TAPS(N_TAPS)) u_dl (
    .clk(clk), .rst_n(rst_n), .wr_en(in_valid && in_ready), .wr_data(in_data),
    .rd_idx(rd_idx), .rd_data(rd_data), .wr_ptr(wr_ptr)
  );
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    newest_d = newest_q;
    acc_d = acc_q;
    out_data_d = out_data_q;
    out_valid_d = out_valid_q;
    coef_d = coef_q;
    if (state_q == IDLE && coef_wr && int'(coef_addr) < N_TAPS) coef_d[coef_addr] = coef_data;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = MAC;
        newest_d = wr_ptr;
        k_d = '0;
      end
      MAC: begin
        acc_d = sum;
        k_d = k_q + 1'b1;
        if (k_q == AW'(N_TAPS - 1)) begin
          out_data_d = sum;
          out_valid_d = 1'b1;
          state_d = OUT;
        end
      end
      OUT: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      k_q <= '0;
      newest_q <= '0;
      acc_q <= '0;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      coef_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      newest_q <= newest_d;
      acc_q <= acc_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      coef_q <= coef_d;
    end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: scoreboard bench with a convolution reference model
module tb_fir_mac_sequencer;
  localparam int N = 3;
  logic clk = 0, rst_n = 0;
  logic signed [8:0] in_data = 0, coef_data = 0;
  logic in_valid = 0, coef_wr = 0, in_ready, out_valid, busy;
  logic [1:0] coef_addr = 0;
  logic signed [19:0] out_data;
  logic out_ready, rnd_ready = 0, rnd_bit = 0, dir_ready = 1;
  assign out_ready = rnd_ready ? rnd_bit : dir_ready;

  fir_mac_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0, tests = 0, fails = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) rnd_bit = 1'($urandom);

  typedef struct { logic signed [19:0] v; int ed; } exp_t;
  exp_t sb[$];
  exp_t e;
  logic signed [8:0] cf [N];
  logic signed [8:0] hist [N];
  logic signed [19:0] held;
  logic pv = 0;

  function automatic void check(string n, longint g, longint x);
    tests++;
    if (g != x) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", n, g, x);
    end
  endfunction

  function automatic logic signed [19:0] model();
    longint a = 0;
    for (int k = 0; k < N; k++) a += longint'(cf[k]) * longint'(hist[k]);
    return a[19:0];
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      cf[k] = 0;
      hist[k] = 0;
    end
  endfunction

  // monitor: pop on each new result, then watch it stay put until consumed
  always @(negedge clk) begin
    if (!rst_n) pv = 0;
    else begin
      if (out_valid && !pv) begin
        if (sb.size() == 0) check("unexpected_result", out_data, 0);
        else begin
          e = sb.pop_front();
          check("result", out_data, e.v);
          check("latency", cyc - e.ed, N);
        end
        held = out_data;
      end else if (out_valid) check("stable", out_data, held);
      if (out_valid) check("in_ready_low", in_ready, 0);
      pv = out_valid;
    end
  end

  task automatic wait_idle();
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready && !out_valid) break;
    end
    if (i == 200) check("idle_timeout", 0, 1);
  endtask

  task automatic wr_coef(input logic [1:0] a, input logic signed [8:0] d);
    wait_idle();
    coef_wr = 1; coef_addr = a; coef_data = d;
    @(posedge clk);
    if (a < N) cf[a] = d;
    @(negedge clk) coef_wr = 0;
  endtask

  task automatic send(input logic signed [8:0] s, input bit w, input logic [1:0] a,
                      input logic signed [8:0] d, input bit mac_wr, output int ed);
    bit got = 0;
    ed = -1;
    @(negedge clk);
    in_data = s; in_valid = 1; coef_wr = w; coef_addr = a; coef_data = d;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk);
      got = in_ready;
    end
    if (!got) check("accept_timeout", 0, 1);
    else begin
      #1 ed = cyc;
      if (w && a < N) cf[a] = d;
      for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = s;
      sb.push_back('{model(), ed});
    end
    @(negedge clk);
    in_valid = 0; coef_wr = 0;
    if (mac_wr && got) begin
      coef_wr = 1; coef_addr = 0; coef_data = 5;
      @(negedge clk) coef_wr = 0;
    end
  endtask

  task automatic snd(input logic signed [8:0] s);
    int ed;
    send(s, 0, 0, 0, 0, ed);
  endtask

  initial begin
    int eb, ea, v;
    model_reset();
    #22;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    @(negedge clk) rst_n = 1;
    #1 check("rst_in_ready", in_ready, 1);

    wr_coef(0, 1); wr_coef(1, 2); wr_coef(2, 3);
    snd(10); snd(-5); snd(4);
    snd(7);

    send(1, 0, 0, 0, 1, ea);
    send(2, 1, 0, 5, 0, ea);
    wr_coef(3, 9);
    snd(0);

    wait_idle();
    dir_ready = 0;
    fork
      begin
        send(20, 0, 0, 0, 0, ea);
        send(30, 0, 0, 0, 0, eb);
      end
      begin
        int i;
        for (i = 0; i < 50; i++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        if (i == 50) check("bp_valid_timeout", 0, 1);
        repeat (5) @(negedge clk);
        dir_ready = 1;
        v = cyc;
      end
    join
    check("bp_accept_edge", eb, v + 2);

    for (int k = 0; k < N; k++) wr_coef(2'(k), -256);
    snd(-256); snd(-256); snd(-256);

    wait_idle();
    rnd_ready = 1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(9'($urandom), ($urandom_range(0, 2) == 0), 2'($urandom), 9'($urandom),
           ($urandom_range(0, 3) == 0), ea);
    end
    rnd_ready = 0;
    dir_ready = 1;
    wait_idle();

    snd(10);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_data", out_data, 0);
    sb.delete();
    model_reset();
    @(negedge clk) rst_n = 1;
    snd(10);
    wr_coef(0, 1); wr_coef(1, 2); wr_coef(2, 3);
    snd(10);

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
